// File: rtl/confreg_bank_pkg.sv
// Shared constants and helpers for the configuration register bank:
// register offsets inside the 64 KiB window and the seven-segment decoder.
package confreg_bank_pkg;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_SEG    = 16'h0040;
  localparam logic [15:0] OFF_TIMER  = 16'h0044;
  localparam logic [15:0] OFF_TCMP   = 16'h0048;
  localparam logic [15:0] OFF_STATUS = 16'h004c;
  localparam logic [15:0] OFF_SW     = 16'h0050;

  localparam logic [31:0] TCMP_RST   = 32'hffff_ffff;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] c;
    case (v)
      4'h0: c = 8'hc0;
      4'h1: c = 8'hf9;
      4'h2: c = 8'ha4;
      4'h3: c = 8'hb0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hf8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h90;
      4'ha: c = 8'h88;
      4'hb: c = 8'h83;
      4'hc: c = 8'hc6;
      4'hd: c = 8'ha1;
      4'he: c = 8'h86;
      default: c = 8'h8e;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/confreg_bank_if.sv
// CPU data-bus access port of the register bank; the CPU side is the master.
interface confreg_bank_if;
  logic        conf_en;
  logic [3:0]  conf_wen;
  logic [31:0] conf_addr;
  logic [31:0] conf_wdata;
  logic [31:0] conf_rdata;

  modport master (
    output conf_en, conf_wen, conf_addr, conf_wdata,
    input  conf_rdata
  );

  modport slave (
    input  conf_en, conf_wen, conf_addr, conf_wdata,
    output conf_rdata
  );
endinterface

// File: rtl/confreg_bank_dffe.sv
// Load-enable storage cell with a parametrised reset value; one instance
// per byte lane gives byte-write registers.
module confreg_bank_dffe #(
  parameter int           W   = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RST;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/confreg_bank_seg7_scan.sv
// Multiplexed eight-digit seven-segment driver: one nibble of seg_data per
// digit slot of SCAN_DIV clocks, with registered anode/cathode outputs.
module seg7_scan
  import confreg_bank_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seg_data,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_digit;
  logic [7:0]    r_an;
  logic [7:0]    r_cat;
  logic [3:0]    w_nibble;
  logic [7:0]    w_cat;

  assign w_nibble = seg_data[{r_digit, 2'b00} +: 4];
  assign w_cat    = hex7(w_nibble);

  // Outputs are refreshed every clock from the current digit, so they trail
  // a digit advance by one cycle and stay stable across the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_digit <= '0;
      r_an    <= 8'hfe;
      r_cat   <= 8'hc0;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre   <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_an  <= ~(8'd1 << r_digit);
      r_cat <= w_cat;
    end
  end

  assign seg_an  = r_an;
  assign seg_cat = r_cat;

endmodule

// File: rtl/confreg_bank.sv
// Memory-mapped configuration bank: LED words, seven-segment data, a
// free-running timer with compare interrupt and a synchronised switch port.
module confreg_bank
  import confreg_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hffff0000,
  parameter int          NUM_LED   = 4,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  confreg_bank_if.slave          bus,
  output logic [32*NUM_LED-1:0]  led,
  input  logic [31:0]            sw,
  output logic [7:0]             seg_an,
  output logic [7:0]             seg_cat,
  output logic                   timer_irq
);

  logic [15:0]            w_offset;
  logic                   w_hit;
  logic                   w_wr;
  logic [NUM_LED-1:0]     w_led_sel;
  logic                   w_sel_seg;
  logic                   w_sel_timer;
  logic                   w_sel_tcmp;
  logic                   w_sel_status;
  logic                   w_sel_sw;
  logic                   w_clr;
  logic [32*NUM_LED-1:0]  w_led;
  logic [31:0]            w_seg;
  logic [31:0]            w_tcmp;
  logic [31:0]            w_timer_next;
  logic [31:0]            w_rdata;

  logic [31:0]            r_timer;
  logic                   r_pending;
  logic [31:0]            r_sw_meta;
  logic [31:0]            r_sw_sync;
  logic [31:0]            r_rdata;

  // A hit needs the window's upper half-word and a word-aligned address.
  assign w_offset     = bus.conf_addr[15:0];
  assign w_hit        = (bus.conf_addr[31:16] == BASE_ADDR[31:16]) &&
                        (bus.conf_addr[1:0] == 2'b00);
  assign w_wr         = bus.conf_en && (|bus.conf_wen);
  assign w_sel_seg    = w_hit && (w_offset == OFF_SEG);
  assign w_sel_timer  = w_hit && (w_offset == OFF_TIMER);
  assign w_sel_tcmp   = w_hit && (w_offset == OFF_TCMP);
  assign w_sel_status = w_hit && (w_offset == OFF_STATUS);
  assign w_sel_sw     = w_hit && (w_offset == OFF_SW);
  assign w_clr        = w_wr && w_sel_status && bus.conf_wen[0] && bus.conf_wdata[0];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_LED; gi++) begin : g_led
      assign w_led_sel[gi] = w_hit && (w_offset == (OFF_LED + 16'(4 * gi)));
      for (gj = 0; gj < 4; gj++) begin : g_byte
        confreg_bank_dffe #(.W(8), .RST(8'h00)) u_led (
          .clk   (clk),
          .reset (reset),
          .i_en  (w_wr && w_led_sel[gi] && bus.conf_wen[gj]),
          .i_d   (bus.conf_wdata[8*gj +: 8]),
          .o_q   (w_led[32*gi + 8*gj +: 8])
        );
      end
    end

    for (gj = 0; gj < 4; gj++) begin : g_lane
      confreg_bank_dffe #(.W(8), .RST(8'h00)) u_seg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wr && w_sel_seg && bus.conf_wen[gj]),
        .i_d   (bus.conf_wdata[8*gj +: 8]),
        .o_q   (w_seg[8*gj +: 8])
      );
      confreg_bank_dffe #(.W(8), .RST(TCMP_RST[8*gj +: 8])) u_tcmp (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wr && w_sel_tcmp && bus.conf_wen[gj]),
        .i_d   (bus.conf_wdata[8*gj +: 8]),
        .o_q   (w_tcmp[8*gj +: 8])
      );
    end
  endgenerate

  // A TIMER write suppresses the increment; unwritten lanes keep the old value.
  always_comb begin
    w_timer_next = r_timer + 32'd1;
    if (w_wr && w_sel_timer) begin
      for (int j = 0; j < 4; j++) begin
        w_timer_next[8*j +: 8] = bus.conf_wen[j] ? bus.conf_wdata[8*j +: 8]
                                                 : r_timer[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_timer   <= w_timer_next;
      r_pending <= (r_timer == w_tcmp) || (r_pending && !w_clr);
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      if (w_led_sel[i]) begin
        w_rdata = w_led[32*i +: 32];
      end
    end
    if (w_sel_seg)    w_rdata = w_seg;
    if (w_sel_timer)  w_rdata = r_timer;
    if (w_sel_tcmp)   w_rdata = w_tcmp;
    if (w_sel_status) w_rdata = {31'd0, r_pending};
    if (w_sel_sw)     w_rdata = r_sw_sync;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (bus.conf_en) begin
      r_rdata <= w_rdata;
    end
  end

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .seg_data (w_seg),
    .seg_an   (seg_an),
    .seg_cat  (seg_cat)
  );

  assign bus.conf_rdata = r_rdata;
  assign led            = w_led;
  assign timer_irq      = r_pending;

endmodule

// File: tb/tb_confreg_bank.sv
// Directed bench for confreg_bank: decode, byte enables, timer/irq, scan, reset.
module tb_confreg_bank;

  localparam logic [31:0] BASE = 32'hffff0000;

  logic         clk;
  logic         reset;
  logic [127:0] led;
  logic [31:0]  sw;
  logic [7:0]   seg_an;
  logic [7:0]   seg_cat;
  logic         timer_irq;

  int n_checks;
  int n_fail;

  logic [7:0] exp_cat [8] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8};

  confreg_bank_if bus ();

  confreg_bank #(.BASE_ADDR(BASE), .NUM_LED(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led       (led),
    .sw        (sw),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle, driven just after an edge; returns 1 time unit after the capturing edge.
  task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    bus.conf_en    = en;
    bus.conf_wen   = wen;
    bus.conf_addr  = a;
    bus.conf_wdata = d;
    @(posedge clk);
    #1;
    bus.conf_en  = 1'b0;
    bus.conf_wen = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input string tag, input logic [7:0] target, input int max);
    int n = 0;
    while (seg_an !== target && n < max) begin
      idle(1);
      n++;
    end
    chk(tag, {24'd0, seg_an}, {24'd0, target});
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    sw             = '0;
    bus.conf_en    = 1'b0;
    bus.conf_wen   = 4'h0;
    bus.conf_addr  = '0;
    bus.conf_wdata = '0;
    idle(3);
    reset = 1'b1;

    // Reset state
    chk("rst_led0", led[31:0], 32'h0);
    chk("rst_led3", led[127:96], 32'h0);
    chk("rst_an", {24'd0, seg_an}, 32'hfe);
    chk("rst_cat", {24'd0, seg_cat}, 32'hc0);
    chk("rst_irq", {31'd0, timer_irq}, 32'h0);
    chk("rst_rdata", bus.conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h48, 32'h0);
    chk("rst_tcmp_rd", bus.conf_rdata, 32'hffffffff);

    // Byte enables
    cyc(1'b1, 4'hf, BASE + 32'h04, 32'h11223344);
    cyc(1'b1, 4'h5, BASE + 32'h04, 32'haabbccdd);
    chk("led1_bytes", led[63:32], 32'h11bb33dd);
    chk("led0_keep", led[31:0], 32'h0);
    chk("led2_keep", led[95:64], 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h04, 32'h0);
    chk("led1_rd", bus.conf_rdata, 32'h11bb33dd);
    cyc(1'b1, 4'h2, BASE + 32'h04, 32'h0000ee00);
    chk("led1_rd_prewrite", bus.conf_rdata, 32'h11bb33dd);
    chk("led1_lane1", led[63:32], 32'h11bbeedd);
    cyc(1'b1, 4'hf, BASE + 32'h0c, 32'hffffffff);
    chk("led3_full", led[127:96], 32'hffffffff);

    // Decode edges
    cyc(1'b1, 4'hf, BASE + 32'h10, 32'h12345678);
    cyc(1'b1, 4'hf, BASE + 32'h41, 32'h12345678);
    cyc(1'b1, 4'hf, BASE + 32'h60, 32'h12345678);
    cyc(1'b1, 4'hf, 32'hfffe0040, 32'h12345678);
    cyc(1'b1, 4'hf, 32'hfffe0004, 32'h12345678);
    chk("dec_led1_keep", led[63:32], 32'h11bbeedd);
    chk("dec_led0_keep", led[31:0], 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h04, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h41, 32'h0);
    chk("dec_misaligned_rd", bus.conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h04, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h60, 32'h0);
    chk("dec_unmapped_rd", bus.conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h04, 32'h0);
    cyc(1'b1, 4'h0, 32'hfffe0040, 32'h0);
    chk("dec_window_rd", bus.conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    chk("dec_led4_rd", bus.conf_rdata, 32'h0);
    cyc(1'b1, 4'h0, BASE + 32'h40, 32'h0);
    chk("dec_seg_keep", bus.conf_rdata, 32'h0);

    // Switch synchroniser; writes to SW are ignored
    sw = 32'h5a5a0000;
    idle(3);
    cyc(1'b1, 4'hf, BASE + 32'h50, 32'hffffffff);
    cyc(1'b1, 4'h0, BASE + 32'h50, 32'h0);
    chk("sw_rd", bus.conf_rdata, 32'h5a5a0000);

    // Timer compare: irq rises 4 cycles after the TIMER write edge
    cyc(1'b1, 4'hf, BASE + 32'h48, 32'd13);
    cyc(1'b1, 4'h0, BASE + 32'h48, 32'h0);
    chk("tcmp_rd", bus.conf_rdata, 32'd13);
    cyc(1'b1, 4'hf, BASE + 32'h44, 32'd10);
    for (int k = 0; k < 4; k++) begin
      chk("irq_before_match", {31'd0, timer_irq}, 32'h0);
      idle(1);
    end
    chk("irq_rise", {31'd0, timer_irq}, 32'h1);
    cyc(1'b1, 4'h0, BASE + 32'h4c, 32'h0);
    chk("status_rd", bus.conf_rdata, 32'h1);
    cyc(1'b1, 4'h1, BASE + 32'h4c, 32'h1);
    chk("irq_w1c", {31'd0, timer_irq}, 32'h0);

    // Clear coincident with a new match: set wins
    cyc(1'b1, 4'hf, BASE + 32'h44, 32'd12);
    idle(1);
    cyc(1'b1, 4'h1, BASE + 32'h4c, 32'h1);
    chk("irq_set_wins", {31'd0, timer_irq}, 32'h1);
    idle(1);
    chk("irq_hold", {31'd0, timer_irq}, 32'h1);
    cyc(1'b1, 4'h1, BASE + 32'h4c, 32'h1);
    chk("irq_w1c2", {31'd0, timer_irq}, 32'h0);

    // Timer wrap and partial write from old value
    cyc(1'b1, 4'hf, BASE + 32'h44, 32'hffffffff);
    cyc(1'b1, 4'h0, BASE + 32'h44, 32'h0);
    chk("timer_max", bus.conf_rdata, 32'hffffffff);
    cyc(1'b1, 4'h0, BASE + 32'h44, 32'h0);
    chk("timer_wrap", bus.conf_rdata, 32'h0);
    cyc(1'b1, 4'hf, BASE + 32'h44, 32'h000001ff);
    cyc(1'b1, 4'h1, BASE + 32'h44, 32'h00000010);
    cyc(1'b1, 4'h0, BASE + 32'h44, 32'h0);
    chk("timer_partial", bus.conf_rdata, 32'h00000110);

    // Seven-segment scan
    cyc(1'b1, 4'hf, BASE + 32'h40, 32'h76543210);
    cyc(1'b1, 4'h0, BASE + 32'h40, 32'h0);
    chk("seg_rd", bus.conf_rdata, 32'h76543210);
    wait_an("scan_sync7", 8'h7f, 64);
    wait_an("scan_sync0", 8'hfe, 64);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("scan_an%0d", d), {24'd0, seg_an}, {24'd0, ~(8'd1 << d)});
      chk($sformatf("scan_cat%0d", d), {24'd0, seg_cat}, {24'd0, exp_cat[d]});
      idle(3);
      chk($sformatf("scan_an%0d_end", d), {24'd0, seg_an}, {24'd0, ~(8'd1 << d)});
      idle(1);
    end
    chk("scan_wrap_an", {24'd0, seg_an}, 32'hfe);
    chk("scan_wrap_cat", {24'd0, seg_cat}, 32'hc0);

    // Async reset mid-scan with irq pending
    cyc(1'b1, 4'hf, BASE + 32'h44, 32'd13);
    idle(1);
    chk("pre_rst_irq", {31'd0, timer_irq}, 32'h1);
    wait_an("pre_rst_digit5", 8'hdf, 64);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_led1", led[63:32], 32'h0);
    chk("arst_led3", led[127:96], 32'h0);
    chk("arst_an", {24'd0, seg_an}, 32'hfe);
    chk("arst_cat", {24'd0, seg_cat}, 32'hc0);
    chk("arst_irq", {31'd0, timer_irq}, 32'h0);
    chk("arst_rdata", bus.conf_rdata, 32'h0);
    idle(2);
    reset = 1'b1;
    cyc(1'b1, 4'h0, BASE + 32'h48, 32'h0);
    chk("arst_tcmp_rd", bus.conf_rdata, 32'hffffffff);
    cyc(1'b1, 4'h0, BASE + 32'h40, 32'h0);
    chk("arst_seg_rd", bus.conf_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/confreg_bank.md
Name: confreg_bank

Overview:
Parametrised configuration/peripheral register bank on the CPU data bus. Generalises the single LED/SEG register pair to NUM_LED byte-writable LED words, a seven-segment scan driver, a free-running timer with compare interrupt, and a synchronised switch input. Decodes a word-aligned window at BASE_ADDR and returns registered read data.

Parameters:
BASE_ADDR, 32'hffff0000, byte address of the register window (64 KiB aligned)
NUM_LED, 4, number of 32-bit LED registers (1..16)
SCAN_DIV, 50000, clk cycles per seven-segment digit (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
conf_en  in  1  bus access strobe
conf_wen  in  4  byte write enables (bit i -> wdata[8i+7:8i]); 0 = read
conf_addr  in  32  byte address
conf_wdata  in  32  write data
conf_rdata  out  32  registered read data
led  out  32*NUM_LED  LED registers, LED[i] at bits [32i+31:32i]
sw  in  32  board switches, asynchronous
seg_an  out  8  digit anodes, one-hot active-low
seg_cat  out  8  segment cathodes {dp,g..a}, active-low
timer_irq  out  1  timer compare interrupt, level

Behaviour:
- Address map (offset = conf_addr - BASE_ADDR; hit only when upper 16 bits match and conf_addr[1:0]==0):
  0x00+4*i LED[i] RW (i<NUM_LED); 0x40 SEG RW; 0x44 TIMER RW; 0x48 TCMP RW; 0x4C STATUS (bit0 irq pending, W1C; other bits read 0); 0x50 SW RO.
- Unmapped or misaligned: reads return 0, writes ignored.
- Write = conf_en && |conf_wen; only enabled bytes update, at the clock edge. Writes to SW ignored.
- Read: on any cycle with conf_en, conf_rdata <= selected register value; otherwise conf_rdata holds. Latency 1 cycle. Read data is the pre-write value when that same cycle also writes the register.
- Reset: LED, SEG, TIMER, conf_rdata, digit counter, prescaler, and irq all 0. TCMP is 32'hffffffff. Synchronizer flops are 0. seg_an = 8'hfe (digit 0), seg_cat = decode(0) = 8'hc0, timer_irq = 0.
- Timer: TIMER increments by 1 every cycle and wraps 0xffffffff -> 0.
  - A write to TIMER replaces the increment that cycle (merged bytes take the written value; unwritten bytes come from the old value, not the incremented one).
  - Compare: pending is set on the cycle after TIMER == TCMP, using the pre-update values.
  - STATUS write with wdata[0]=1 and wen[0]=1 clears pending.
  - Set and clear in the same cycle: set wins.
  - timer_irq = pending.
- SW: two-flop synchronizer; reads return the second stage (2-3 cycle latency from a pin change).
- Seg scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, digit d advances 0..7 and wraps 7 -> 0.
  - seg_an = ~(1<<d).
  - seg_cat = hex7 decode of SEG[4d+3:4d], dp off (bit7=1).
  - Outputs are registered: they change one cycle after the digit advance.
  - A SEG write takes effect at the next registered update, with no glitch within a digit slot.
- Reset asserted mid-operation clears all state asynchronously; the deassertion edge is synchronous.

Decomposition:
- Package confreg_bank_pkg: offset constants (OFF_LED, OFF_SEG, OFF_TIMER, OFF_TCMP, OFF_STATUS, OFF_SW), TCMP reset value, hex7 decode function (16 entries, active-low).
- Sub-module seg7_scan (params SCAN_DIV; ports clk, reset, seg_data[31:0], seg_an, seg_cat): holds prescaler, digit counter, output regs.
- Storage uses the existing load-enable DFF cells, with one instance per byte lane for byte-enabled registers.

Test Plan:
- Reset: release reset -> led=0, seg_an=8'hfe, seg_cat=8'hc0, timer_irq=0. Read TCMP -> conf_rdata=32'hffffffff one cycle later.
- Byte enables: write LED[1]=32'h11223344 with wen=4'hf. Then write 32'haabbccdd with wen=4'h5 -> led[63:32]=32'h11bb33dd. LED[0], LED[2], LED[3] unchanged. A read returns the same value after 1 cycle.
- Decode edges: write to BASE+0x41 (misaligned), BASE+0x60, and 32'hfffe0040 -> no register changes, reads return 0. Write SW -> ignored, and a read returns synced sw=32'h5a5a0000 set 3 cycles earlier.
- Timer/irq: write TIMER=10 and TCMP=13 -> timer_irq rises exactly 4 cycles after the TIMER write. W1C STATUS -> drops next cycle. Clear coincident with a new match -> stays 1. Write TIMER=32'hffffffff -> wraps to 0.
- Seg scan (SCAN_DIV=4): write SEG=32'h76543210 -> seg_an walks fe,fd,..,7f every 4 cycles. seg_cat follows c0,f9,a4,b0,99,92,82,f8, then wraps to fe.
- Async reset mid-scan (at digit 5 with pending irq set) -> all outputs return to reset values immediately, without waiting for a clock edge.
